shift_reg_seq: RTL and testbench
================================

// Module: shift_reg_seq
// PURPOSE
//  Sequencer for the 4-bit bidirectional serial shift register (S_in/dir/enable/S_out datapath).
//  - Takes a parallel word over a valid/ready handshake.
//  - Streams the word into the register one bit per shift strobe.
//  - Captures the WIDTH bits that fall out of S_out into a parallel word.
//  - Each transaction therefore swaps the new word in and returns the previously stored word.
//  - Sits between the FIFO/memory control logic and the shift register instance.
// PARAMETERS
//  WIDTH  4  bits per transaction; must equal the shift register length
//  DIV    1  clk cycles per shift strobe (>=1); one sr_enable pulse every DIV cycles
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-low reset
//  tx_data    in   WIDTH  word to shift in
//  tx_valid   in   1      tx_data valid
//  tx_ready   out  1      high in IDLE only; accept = tx_valid & tx_ready at clk edge
//  msb_first  in   1      bit order, sampled at accept: 1 = tx_data[WIDTH-1] first
//  shift_dir  in   1      sampled at accept, driven on sr_dir for the whole transaction
//  sr_S_in    out  1      serial bit to the register's S_in
//  sr_dir     out  1      register dir (1: S_in enters Q[0], exits Q[WIDTH-1])
//  sr_enable  out  1      one-cycle shift strobe to the register's enable
//  sr_S_out   in   1      register's S_out (bit leaving on the next strobe)
//  rx_data    out  WIDTH  word captured from sr_S_out
//  rx_valid   out  1      rx_data valid; held until rx_ready
//  rx_ready   in   1      consumer accepts rx_data
//  busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state=IDLE; all counters 0.
//    tx_ready=1; sr_S_in, sr_dir, sr_enable, rx_data, rx_valid, busy all 0.
//  - Reset has priority over every other event, including mid-SHIFT.
//  - Mid-SHIFT reset: the transaction is abandoned with no rx_valid.
//    Register contents are left as-is; the controller never clears them.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE:
//    - On accept: latch tx_data, msb_first, shift_dir; clear bit_cnt and div_cnt; go to SHIFT.
//    - tx_valid while not in IDLE is ignored (tx_ready=0).
//  - SHIFT:
//    - div_cnt counts 0..DIV-1 and wraps; sr_enable=1 exactly when div_cnt==DIV-1.
//    - sr_S_in = current tx bit (index WIDTH-1-bit_cnt if msb_first, else bit_cnt); stable for the whole bit period.
//    - In each sr_enable cycle, sample sr_S_out into rx bit (same index mapping as tx) and increment bit_cnt.
//    - After the enable with bit_cnt==WIDTH-1: go to DONE; sr_enable returns to 0.
//  - DONE: rx_valid=1, rx_data stable. On rx_ready: rx_valid drops and state returns to IDLE.
//    - Earliest next accept is the cycle after the return to IDLE (no IDLE-cycle bypass).
//  - Timing, accept at edge t:
//    - First sr_enable cycle is t+DIV.
//    - Last sr_enable cycle is t+WIDTH*DIV.
//    - rx_valid is first high at t+WIDTH*DIV+1.
//  - sr_dir holds the latched shift_dir from accept until return to IDLE; it is 0 in IDLE.
//  - Round trip: same msb_first/shift_dir on consecutive transactions returns the previous tx word unchanged.
//  - rx_valid held with rx_ready=0: rx_data, sr_dir and busy stay frozen; tx_ready stays 0.
// CONFIGURATION
//  SHIFT_SEQ_FLUSH_EN
//  - Defined: adds input `flush` (1 bit).
//    - flush=1 in IDLE (tx_valid ignored that cycle) runs a full WIDTH-strobe SHIFT with sr_S_in=0.
//    - Captured bits are discarded: no DONE state and no rx_valid; the FSM returns directly to IDLE.
//    - busy=1 during the flush.
//  - Not defined: no flush port; behaviour exactly as above.
// TESTING (WIDTH=4 unless noted)
//  1. Reset, then shift-register reset; send 4'hA, msb_first=1, shift_dir=1, DIV=1.
//     -> sr_S_in=1,0,1,0 on 4 consecutive enables; rx_data=4'h0 at t+5.
//  2. Then send 4'h5 with the same settings -> rx_data=4'hA. Then send 4'h3, msb_first=0 -> rx_data=4'h5.
//  3. DIV=3, send 4'hC -> sr_enable high at t+3, t+6, t+9, t+12 only; rx_valid first high at t+13.
//  4. Hold rx_ready=0 for 5 cycles in DONE with tx_valid=1.
//     -> rx_valid and rx_data held, tx_ready=0, no second accept.
//  5. Assert reset after 2 enables -> next cycle state IDLE, all outputs 0, tx_ready=1; no rx_valid ever.
//  6. With SHIFT_SEQ_FLUSH_EN: after 4'hF stored, pulse flush -> 4 enables with sr_S_in=0, no rx_valid.
//     The next 4'h1 transaction returns rx_data=4'h0.

Source files
------------

// File: rtl/shift_reg_seq.sv
// Sequencer for a WIDTH-bit bidirectional serial shift register: swaps a new word in, returns the old one.
// Optional flush feature enabled by defining SHIFT_SEQ_FLUSH_EN (adds input `flush`).
module shift_reg_seq #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             msb_first,
  input  logic             shift_dir,
`ifdef SHIFT_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  output logic             sr_S_in,
  output logic             sr_dir,
  output logic             sr_enable,
  input  logic             sr_S_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             msb_q, msb_d;
  logic             dir_q, dir_d;
  logic             flush_q, flush_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    idx;
  logic             strobe;
  logic             flush_req;

`ifdef SHIFT_SEQ_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    msb_d     = msb_q;
    dir_d     = dir_q;
    flush_d   = flush_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    // Same bit index maps the outgoing tx bit and the incoming rx bit.
    idx       = msb_q ? (BW'(WIDTH - 1) - bit_cnt_q) : bit_cnt_q;
    strobe    = (state_q == SHIFT) && (div_cnt_q == DW'(DIV - 1));

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          tx_d      = '0;
          msb_d     = 1'b1;
          dir_d     = shift_dir;
          flush_d   = 1'b1;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end else if (tx_valid) begin
          tx_d      = tx_data;
          rx_d      = '0;
          msb_d     = msb_first;
          dir_d     = shift_dir;
          flush_d   = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        div_cnt_d = strobe ? '0 : div_cnt_q + DW'(1);
        if (strobe) begin
          if (!flush_q) rx_d[idx] = sr_S_out;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = flush_q ? IDLE : DONE;
          end
        end
      end
      DONE: begin
        if (rx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rx_q      <= '0;
      msb_q     <= 1'b0;
      dir_q     <= 1'b0;
      flush_q   <= 1'b0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      msb_q     <= msb_d;
      dir_q     <= dir_d;
      flush_q   <= flush_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Outgoing word needs no reset: sr_S_in is gated off outside SHIFT.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rx_valid  = (state_q == DONE);
  assign sr_enable = strobe;
  assign sr_S_in   = (state_q == SHIFT) & tx_q[idx];
  assign sr_dir    = (state_q != IDLE) & dir_q;
  assign rx_data   = rx_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: instance A (DIV=1) and instance B (DIV=3), each driving a 4-bit shift register model.
// Flush scenario runs only when SHIFT_SEQ_FLUSH_EN is defined.
module tb_shift_reg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_reset, a_tx_valid, a_tx_ready, a_msb, a_dir, a_sr_S_in, a_sr_dir, a_sr_enable;
  logic       a_sr_S_out, a_rx_valid, a_rx_ready, a_busy, a_flush, a_sr_clr;
  logic [3:0] a_tx_data, a_rx_data, a_q;
  logic       b_reset, b_tx_valid, b_tx_ready, b_msb, b_dir, b_sr_S_in, b_sr_dir, b_sr_enable;
  logic       b_sr_S_out, b_rx_valid, b_rx_ready, b_busy, b_flush, b_sr_clr;
  logic [3:0] b_tx_data, b_rx_data, b_q;

  shift_reg_seq #(.WIDTH(4), .DIV(1)) dut_a (
    .clk(clk), .reset(a_reset), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .msb_first(a_msb), .shift_dir(a_dir),
`ifdef SHIFT_SEQ_FLUSH_EN
    .flush(a_flush),
`endif
    .sr_S_in(a_sr_S_in), .sr_dir(a_sr_dir), .sr_enable(a_sr_enable), .sr_S_out(a_sr_S_out),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .busy(a_busy)
  );

  shift_reg_seq #(.WIDTH(4), .DIV(3)) dut_b (
    .clk(clk), .reset(b_reset), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .msb_first(b_msb), .shift_dir(b_dir),
`ifdef SHIFT_SEQ_FLUSH_EN
    .flush(b_flush),
`endif
    .sr_S_in(b_sr_S_in), .sr_dir(b_sr_dir), .sr_enable(b_sr_enable), .sr_S_out(b_sr_S_out),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .busy(b_busy)
  );

  // Bidirectional shift register models: dir=1 enters Q[0] / exits Q[3]; dir=0 enters Q[3] / exits Q[0].
  always @(posedge clk) begin
    if (a_sr_clr) a_q <= 4'h0;
    else if (a_sr_enable) a_q <= a_sr_dir ? {a_q[2:0], a_sr_S_in} : {a_sr_S_in, a_q[3:1]};
    if (b_sr_clr) b_q <= 4'h0;
    else if (b_sr_enable) b_q <= b_sr_dir ? {b_q[2:0], b_sr_S_in} : {b_sr_S_in, b_q[3:1]};
  end
  assign a_sr_S_out = a_sr_dir ? a_q[3] : a_q[0];
  assign b_sr_S_out = b_sr_dir ? b_q[3] : b_q[0];

  task automatic test_reset();
    a_reset = 1'b0; b_reset = 1'b0; a_sr_clr = 1'b1; b_sr_clr = 1'b1;
    a_tx_valid = 1'b1; b_tx_valid = 1'b1; a_tx_data = 4'hF; b_tx_data = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_tx_ready, a_busy, a_rx_valid, a_sr_enable, a_sr_S_in, a_sr_dir, a_rx_data} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_a: got rdy/busy/rxv/en/sin/dir/rx=%b want 1000000000",
               {a_tx_ready, a_busy, a_rx_valid, a_sr_enable, a_sr_S_in, a_sr_dir, a_rx_data});
    end
    checks++;
    if ({b_tx_ready, b_busy, b_rx_valid, b_sr_enable, b_sr_S_in, b_sr_dir, b_rx_data} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_b: got rdy/busy/rxv/en/sin/dir/rx=%b want 1000000000",
               {b_tx_ready, b_busy, b_rx_valid, b_sr_enable, b_sr_S_in, b_sr_dir, b_rx_data});
    end
    a_tx_valid = 1'b0; b_tx_valid = 1'b0; a_tx_data = 4'h0; b_tx_data = 4'h0;
    a_reset = 1'b1; b_reset = 1'b1; a_sr_clr = 1'b0; b_sr_clr = 1'b0;
  endtask

  // One full DIV=1 transaction on instance A, released with rx_ready after rx_valid is seen.
  task automatic a_xfer(input logic [3:0] d, input logic msb, input logic dir,
                        input logic [3:0] exp_rx, input string name);
    logic eb;
    @(negedge clk);
    checks++;
    if (a_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b want 1", name, a_tx_ready);
    end
    a_tx_data = d; a_msb = msb; a_dir = dir; a_tx_valid = 1'b1;
    @(posedge clk);
    #1 a_tx_valid = 1'b0; a_tx_data = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        eb = msb ? d[4-k] : d[k-1];
        checks++;
        if ({a_sr_enable, a_sr_S_in, a_sr_dir, a_busy, a_rx_valid} !== {1'b1, eb, dir, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL %s_bit%0d: got en/sin/dir/busy/rxv=%b want %b", name, k,
                   {a_sr_enable, a_sr_S_in, a_sr_dir, a_busy, a_rx_valid}, {1'b1, eb, dir, 1'b1, 1'b0});
        end
      end else begin
        checks++;
        if ({a_rx_valid, a_rx_data, a_sr_enable, a_sr_dir} !== {1'b1, exp_rx, 1'b0, dir}) begin
          errors++;
          $display("FAIL %s_rx: got rxv=%b rx=%h en=%b dir=%b want rxv=1 rx=%h en=0 dir=%b", name,
                   a_rx_valid, a_rx_data, a_sr_enable, a_sr_dir, exp_rx, dir);
        end
      end
    end
    a_rx_ready = 1'b1;
    @(posedge clk);
    #1 a_rx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_tx_ready, a_rx_valid, a_busy, a_sr_dir} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_idle: got rdy/rxv/busy/dir=%b want 1000", name,
               {a_tx_ready, a_rx_valid, a_busy, a_sr_dir});
    end
  endtask

  task automatic test_basic();
    a_xfer(4'hA, 1'b1, 1'b1, 4'h0, "basicA");
  endtask

  task automatic test_back_to_back();
    a_xfer(4'h5, 1'b1, 1'b1, 4'hA, "b2b5");
    a_xfer(4'h3, 1'b0, 1'b0, 4'h5, "b2b3");
    a_xfer(4'hF, 1'b1, 1'b1, 4'h3, "b2bF");
  endtask

  task automatic test_flush();
    a_flush = 1'b0;
`ifdef SHIFT_SEQ_FLUSH_EN
    @(negedge clk);
    a_flush = 1'b1; a_tx_valid = 1'b1; a_tx_data = 4'h7; a_dir = 1'b1;
    @(posedge clk);
    #1 a_flush = 1'b0; a_tx_valid = 1'b0; a_tx_data = 4'h0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        if ({a_sr_enable, a_sr_S_in, a_busy, a_rx_valid} !== 4'b1010) begin
          errors++;
          $display("FAIL flush_bit%0d: got en/sin/busy/rxv=%b want 1010", k,
                   {a_sr_enable, a_sr_S_in, a_busy, a_rx_valid});
        end
      end else if ({a_sr_enable, a_busy, a_rx_valid, a_tx_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL flush_end%0d: got en/busy/rxv/rdy=%b want 0001", k,
                 {a_sr_enable, a_busy, a_rx_valid, a_tx_ready});
      end
    end
    checks++;
    if (a_q !== 4'h0) begin
      errors++;
      $display("FAIL flush_reg: got %h want 0", a_q);
    end
    a_xfer(4'h1, 1'b1, 1'b1, 4'h0, "postflush");
`endif
  endtask

  task automatic test_div3();
    logic exp_en;
    logic [3:0] d;
    d = 4'hC;
    @(negedge clk);
    b_tx_data = d; b_msb = 1'b1; b_dir = 1'b1; b_tx_valid = 1'b1;
    @(posedge clk);
    #1 b_tx_valid = 1'b0; b_tx_data = 4'h0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_en = (k % 3 == 0);
      checks++;
      if ({b_sr_enable, b_rx_valid} !== {exp_en, k == 13}) begin
        errors++;
        $display("FAIL div3_t%0d: got en/rxv=%b%b want %b%b", k, b_sr_enable, b_rx_valid, exp_en, k == 13);
      end
      if (exp_en) begin
        checks++;
        if (b_sr_S_in !== d[3-(k/3-1)]) begin
          errors++;
          $display("FAIL div3_sin%0d: got %b want %b", k, b_sr_S_in, d[3-(k/3-1)]);
        end
      end
    end
    checks++;
    if (b_rx_data !== 4'h0) begin
      errors++;
      $display("FAIL div3_rx: got %h want 0", b_rx_data);
    end
  endtask

  task automatic test_hold();
    b_tx_valid = 1'b1; b_tx_data = 4'h5; b_rx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({b_rx_valid, b_rx_data, b_tx_ready, b_busy, b_sr_dir, b_sr_enable} !== 9'b1_0000_0110) begin
        errors++;
        $display("FAIL hold%0d: got rxv/rx/rdy/busy/dir/en=%b want 100000110", k,
                 {b_rx_valid, b_rx_data, b_tx_ready, b_busy, b_sr_dir, b_sr_enable});
      end
    end
    b_tx_valid = 1'b0; b_tx_data = 4'h0; b_rx_ready = 1'b1;
    @(posedge clk);
    #1 b_rx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_tx_ready, b_rx_valid, b_busy} !== 3'b100) begin
      errors++;
      $display("FAIL hold_release: got rdy/rxv/busy=%b want 100", {b_tx_ready, b_rx_valid, b_busy});
    end
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    @(negedge clk);
    b_tx_data = 4'h9; b_msb = 1'b1; b_dir = 1'b1; b_tx_valid = 1'b1;
    @(posedge clk);
    #1 b_tx_valid = 1'b0; b_tx_data = 4'h0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    checks++;
    if (b_sr_enable !== 1'b1) begin
      errors++;
      $display("FAIL midrst_en2: got %b want 1", b_sr_enable);
    end
    b_reset = 1'b0;
    @(posedge clk);
    #1 b_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({b_tx_ready, b_busy, b_rx_valid, b_sr_enable, b_sr_S_in, b_sr_dir, b_rx_data} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL midrst_out: got rdy/busy/rxv/en/sin/dir/rx=%b want 1000000000",
               {b_tx_ready, b_busy, b_rx_valid, b_sr_enable, b_sr_S_in, b_sr_dir, b_rx_data});
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_rx_valid !== 1'b0 || b_busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_quiet: got activity=1 want 0");
    end
  endtask

  initial begin
    a_reset = 1'b0; b_reset = 1'b0; a_sr_clr = 1'b1; b_sr_clr = 1'b1;
    a_tx_data = 4'h0; a_tx_valid = 1'b0; a_msb = 1'b0; a_dir = 1'b0; a_rx_ready = 1'b0; a_flush = 1'b0;
    b_tx_data = 4'h0; b_tx_valid = 1'b0; b_msb = 1'b0; b_dir = 1'b0; b_rx_ready = 1'b0; b_flush = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_div3();
    test_hold();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
